// File: rtl/wb_write_port.sv
// -----------------------------------------------------------------------------
// wb_write_port -- MIPS writeback stage
//
// Owns the MEM/WB pipeline register. Formats load data, selects the ALU result
// or the memory data, and drives the Decode register-file write port. It also
// merges a second write source, the multi-cycle mul/div unit, through a
// 1-entry buffer. If that buffer waits too long behind pipeline writes, it
// raises stall_req to force a bubble.
//
// Optional feature macro: WB_FWD_EN
//   defined   : fwd_* repeat reg_write/rd/write_data one cycle later, from
//               registers, so Decode can bypass a write that has just been
//               committed.
//   undefined : fwd_* ports are present and tied to zero.
//
// Parameters
//   AUX_MAX_WAIT  cycles an occupied aux buffer may wait before stall_req is
//                 raised (1..15)
//
// Ports
//   clk             in   pipeline clock, rising edge
//   reset           in   synchronous, active-high reset
//   flush           in   load a bubble into the WB register at this edge
//   mem_valid       in   MEM stage presents an instruction
//   mem_reg_write   in   instruction writes a GPR
//   mem_mem_to_reg  in   1 = load data, 0 = ALU result
//   mem_load_type   in   000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU (others LW)
//   mem_addr_lo     in   byte address bits [1:0] of the load
//   mem_rd          in   destination register
//   mem_alu_result  in   ALU result
//   mem_read_data   in   raw data-memory word
//   aux_valid       in   mul/div result offered
//   aux_rd          in   mul/div destination
//   aux_data        in   mul/div result
//   aux_ready       out  buffer empty; an offer is accepted at this edge
//   stall_req       out  upstream must hold MEM and present it again
//   reg_write       out  register-file write enable
//   rd              out  register-file write address
//   write_data      out  register-file write data
//   wb_retire       out  the WB register holds a valid instruction
//   fwd_valid       out  forwarding valid
//   fwd_rd          out  forwarding register
//   fwd_data        out  forwarding data
// -----------------------------------------------------------------------------
module wb_write_port #(
    parameter int AUX_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic        mem_mem_to_reg,
    input  logic [2:0]  mem_load_type,
    input  logic [1:0]  mem_addr_lo,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_read_data,
    input  logic        aux_valid,
    input  logic [4:0]  aux_rd,
    input  logic [31:0] aux_data,
    output logic        aux_ready,
    output logic        stall_req,
    output logic        reg_write,
    output logic [4:0]  rd,
    output logic [31:0] write_data,
    output logic        wb_retire,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data
);

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    localparam logic [3:0] MAX_CNT = 4'(AUX_MAX_WAIT);

    // ---------------------------------------------------------------------
    // MEM/WB pipeline register
    // ---------------------------------------------------------------------
    logic        valid_q, valid_d;
    logic        reg_write_q;
    logic        mem_to_reg_q;
    logic [2:0]  load_type_q;
    logic [1:0]  addr_lo_q;
    logic [4:0]  rd_q;
    logic [31:0] alu_q;
    logic [31:0] rdata_q;

    // ---------------------------------------------------------------------
    // Aux (mul/div) buffer and starvation counter
    // ---------------------------------------------------------------------
    logic        aux_full_q, aux_full_d;
    logic [4:0]  aux_rd_q, aux_rd_d;
    logic [31:0] aux_data_q, aux_data_d;
    logic [3:0]  aux_cnt_q, aux_cnt_d;

    logic        pipe_wr;
    logic        drain;
    logic        aux_accept;
    logic [31:0] load_data;
    logic [31:0] pipe_data;

    // A stall squashes the instruction now in MEM. Upstream holds it and
    // presents it again, so it is captured one cycle later.
    assign valid_d = mem_valid & ~flush & ~stall_req;

    // A pipeline write to $0 is never issued, so it does not block the drain.
    assign pipe_wr = valid_q & reg_write_q & (rd_q != 5'd0);
    assign drain   = aux_full_q & ~pipe_wr;

    assign aux_ready  = ~aux_full_q;
    // An offer to $0 completes the handshake but is not stored.
    assign aux_accept = aux_valid & aux_ready & (aux_rd != 5'd0);

    assign stall_req = aux_full_q & ~drain & (aux_cnt_q == MAX_CNT);
    assign wb_retire = valid_q;

    // ---------------------------------------------------------------------
    // Load formatting (little-endian, lane = addr_lo)
    // ---------------------------------------------------------------------
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = rdata_q[{addr_lo_q, 3'b000} +: 8];
    // For halfword loads only addr_lo[1] matters; bit 0 is ignored.
    assign sel_half = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        // NOTE: assigning a default first means every path drives load_data,
        // so no latch is inferred.
        load_data = rdata_q;
        case (load_type_q)
            LT_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            LT_LBU:  load_data = {24'd0, sel_byte};
            LT_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            LT_LHU:  load_data = {16'd0, sel_half};
            LT_LW:   load_data = rdata_q;
            default: load_data = rdata_q;
        endcase
    end

    assign pipe_data = mem_to_reg_q ? load_data : alu_q;

    // ---------------------------------------------------------------------
    // Register-file write port: pipeline first, then aux buffer, else idle
    // ---------------------------------------------------------------------
    always_comb begin
        reg_write  = 1'b0;
        rd         = 5'd0;
        write_data = 32'd0;
        if (pipe_wr) begin
            reg_write  = 1'b1;
            rd         = rd_q;
            write_data = pipe_data;
        end else if (aux_full_q) begin
            reg_write  = 1'b1;
            rd         = aux_rd_q;
            write_data = aux_data_q;
        end
    end

    // ---------------------------------------------------------------------
    // Aux buffer next state. No accept can happen during a drain, because
    // ready is low while the buffer is full.
    // ---------------------------------------------------------------------
    always_comb begin
        aux_full_d = aux_full_q;
        aux_rd_d   = aux_rd_q;
        aux_data_d = aux_data_q;
        if (drain) begin
            aux_full_d = 1'b0;
        end else if (aux_accept) begin
            aux_full_d = 1'b1;
            aux_rd_d   = aux_rd;
            aux_data_d = aux_data;
        end
    end

    // The wait counter runs only while the buffer is blocked. It saturates,
    // so stall_req stays high until the forced bubble lets the buffer drain.
    always_comb begin
        aux_cnt_d = aux_cnt_q;
        if (!aux_full_q || drain) begin
            aux_cnt_d = 4'd0;
        end else if (aux_cnt_q != MAX_CNT) begin
            aux_cnt_d = aux_cnt_q + 4'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Control state: synchronous reset
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample the
        // values from before the edge, whatever order the statements are in.
        if (reset) begin
            valid_q    <= 1'b0;
            aux_full_q <= 1'b0;
            aux_cnt_q  <= 4'd0;
        end else begin
            valid_q    <= valid_d;
            aux_full_q <= aux_full_d;
            aux_cnt_q  <= aux_cnt_d;
        end
    end

    // NOTE: the payload registers have no reset. Every use of them is gated
    // by valid_q or aux_full_q, and both of those are reset.
    always_ff @(posedge clk) begin
        reg_write_q  <= mem_reg_write;
        mem_to_reg_q <= mem_mem_to_reg;
        load_type_q  <= mem_load_type;
        addr_lo_q    <= mem_addr_lo;
        rd_q         <= mem_rd;
        alu_q        <= mem_alu_result;
        rdata_q      <= mem_read_data;
        aux_rd_q     <= aux_rd_d;
        aux_data_q   <= aux_data_d;
    end

    // ---------------------------------------------------------------------
    // Forwarding of the write committed at the previous edge
    // ---------------------------------------------------------------------
`ifdef WB_FWD_EN
    logic        fwd_valid_q;
    logic [4:0]  fwd_rd_q;
    logic [31:0] fwd_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_valid_q <= 1'b0;
            fwd_rd_q    <= 5'd0;
            fwd_data_q  <= 32'd0;
        end else begin
            fwd_valid_q <= reg_write;
            fwd_rd_q    <= rd;
            fwd_data_q  <= write_data;
        end
    end

    assign fwd_valid = fwd_valid_q;
    assign fwd_rd    = fwd_rd_q;
    assign fwd_data  = fwd_data_q;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = 5'd0;
    assign fwd_data  = 32'd0;
`endif

endmodule
